// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter that shares one WIDTH-bit enabled DFF
//               register bank between N_REQ requesters. It drives the bank's
//               enable (o_en) and data (o_d) so the bank loads exactly one
//               requester's data per write pulse. An owner may hold i_lock
//               to issue back-to-back writes without re-arbitrating.
//
// Ports       : i_clk          clock, rising edge
//               i_rst          synchronous active-high reset
//               i_req          per-requester write request (level)
//               i_lock         per-requester keep-grant request
//               i_data         write data, requester k at [k*WIDTH +: WIDTH]
//               o_gnt          one-hot grant or zero
//               o_ack          one-cycle pulse to owner with its write
//               o_en           register bank enable
//               o_d            register bank data
//               o_owner        current owner index (valid while o_gnt != 0)
//               o_busy         high in WRITE or LOCKED
//               o_hold_expired one-cycle pulse on forced release
//
// Options     : REG_ARB_HOLD_LIMIT_EN - when defined, an owner is forcibly
//               released once its tenure counter reaches MAX_HOLD. When not
//               defined, o_hold_expired is constant 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ-1:0]           i_lock,
    input  logic [N_REQ*WIDTH-1:0]     i_data,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [N_REQ-1:0]           o_ack,
    output logic                       o_en,
    output logic [WIDTH-1:0]           o_d,
    output logic [$clog2(N_REQ)-1:0]   o_owner,
    output logic                       o_busy,
    output logic                       o_hold_expired
);

    localparam int c_IDX_W = $clog2(N_REQ);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_WRITE  = 2'd1;
    localparam logic [1:0] c_S_LOCKED = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_ack;
    logic               r_en;
    logic [WIDTH-1:0]   r_d;
    logic [c_IDX_W-1:0] r_owner;
    logic               r_busy;
    logic               r_hold_expired;

    logic [WIDTH-1:0]   w_data [N_REQ];
    logic [N_REQ-1:0]   w_hi_req;
    logic [c_IDX_W-1:0] w_winner;
    logic [N_REQ-1:0]   w_winner_oh;
    logic               w_expire;
    logic               w_release;

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
            assign w_data[k] = i_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting at ptr+1: prefer the lowest requester
    // strictly above ptr, otherwise wrap to the lowest requester overall.
    always_comb begin
        w_hi_req    = '0;
        w_winner    = '0;
        w_winner_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_hi_req[k] = i_req[k] && (c_IDX_W'(k) > r_ptr);
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_winner = c_IDX_W'(k);
            end
        end
        if (|w_hi_req) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (w_hi_req[k]) begin
                    w_winner = c_IDX_W'(k);
                end
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            w_winner_oh[k] = (w_winner == c_IDX_W'(k));
        end
    end

`ifdef REG_ARB_HOLD_LIMIT_EN
    localparam int c_TEN_W = $clog2(MAX_HOLD + 1);

    logic [c_TEN_W-1:0] r_tenure;

    // Zero while idle, so it starts at 0 in the grant's WRITE cycle and then
    // counts every WRITE/LOCKED cycle of the tenure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tenure <= '0;
        end else if (r_state == c_S_IDLE) begin
            r_tenure <= '0;
        end else begin
            r_tenure <= r_tenure + 1'b1;
        end
    end

    assign w_expire = (r_state != c_S_IDLE) && (r_tenure == c_TEN_W'(MAX_HOLD));
`else
    assign w_expire = 1'b0;
`endif

    // Leaving the owner's tenure: either the lock is not held or the hold
    // limit fired. In WRITE the write pulse has already gone out.
    assign w_release = (r_state != c_S_IDLE) && (w_expire || !i_lock[r_owner]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= c_S_IDLE;
            r_ptr          <= c_IDX_W'(N_REQ - 1);
            r_gnt          <= '0;
            r_ack          <= '0;
            r_en           <= 1'b0;
            r_d            <= '0;
            r_owner        <= '0;
            r_busy         <= 1'b0;
            r_hold_expired <= 1'b0;
        end else begin
            r_en           <= 1'b0;
            r_ack          <= '0;
            r_hold_expired <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (|i_req) begin
                        r_gnt   <= w_winner_oh;
                        r_ack   <= w_winner_oh;
                        r_owner <= w_winner;
                        r_d     <= w_data[w_winner];
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= c_S_WRITE;
                    end
                end
                c_S_WRITE, c_S_LOCKED: begin
                    if (w_release) begin
                        r_gnt          <= '0;
                        r_busy         <= 1'b0;
                        r_ptr          <= r_owner;
                        r_hold_expired <= w_expire;
                        r_state        <= c_S_IDLE;
                    end else if (r_state == c_S_WRITE) begin
                        r_state <= c_S_LOCKED;
                    end else if (i_req[r_owner]) begin
                        // r_gnt is already one-hot of the owner.
                        r_d     <= w_data[r_owner];
                        r_en    <= 1'b1;
                        r_ack   <= r_gnt;
                        r_state <= c_S_WRITE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt          = r_gnt;
    assign o_ack          = r_ack;
    assign o_en           = r_en;
    assign o_d            = r_d;
    assign o_owner        = r_owner;
    assign o_busy         = r_busy;
    assign o_hold_expired = r_hold_expired;

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit enabled DFF register bank between N_REQ requesters.
- Generates the bank's enable and data, so the bank loads exactly one requester's data per write pulse.
- Supports an optional lock so one owner can issue back-to-back writes without re-arbitrating.
- Sits between requester logic and the shared register bank, directly driving its enable and D inputs.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, register bank data width.
- MAX_HOLD, 15, max cycles an owner may hold the grant (used only with the optional feature).

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_req  input  N_REQ  per-requester write request.
- i_lock  input  N_REQ  per-requester request to keep the grant after a write.
- i_data  input  N_REQ*WIDTH  write data; requester k occupies bits [k*WIDTH +: WIDTH].
- o_gnt  output  N_REQ  one-hot grant, or all zero.
- o_ack  output  N_REQ  one-cycle pulse to the owner, coincident with its write.
- o_en  output  1  enable to the register bank.
- o_d  output  WIDTH  data to the register bank.
- o_owner  output  clog2(N_REQ)  index of the current owner; valid while o_gnt is non-zero.
- o_busy  output  1  high in WRITE or LOCKED.
- o_hold_expired  output  1  one-cycle pulse on forced release.

Behaviour:
- All outputs registered. Reset is synchronous, active-high on i_rst.
- Reset values: o_gnt=0, o_ack=0, o_en=0, o_d=0, o_owner=0, o_busy=0, o_hold_expired=0; state=IDLE; priority pointer ptr=N_REQ-1, so requester 0 wins first.
- i_rst takes precedence over every other event, including mid-WRITE and mid-LOCKED. An in-flight o_en pulse is cut to 0 on the next edge.
- States: IDLE, WRITE, LOCKED.
- IDLE, no request:
  - If i_req==0, hold all outputs.
- IDLE, any i_req bit set:
  - Winner is the first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
  - Load o_gnt=onehot(winner), o_owner=winner, o_d=i_data[winner].
  - Set o_en=1, o_ack=onehot(winner), o_busy=1; go to WRITE.
  - Latency: request sampled at edge t gives grant, write and ack visible after edge t.
- WRITE (lasts exactly one cycle):
  - Next edge clears o_en and o_ack. o_d holds its value.
  - If i_lock[owner]=1: go to LOCKED, o_gnt held.
  - Else: o_gnt=0, o_busy=0, ptr=owner; go to IDLE.
- LOCKED:
  - Other requesters are ignored.
  - If i_lock[owner]=0: release (o_gnt=0, o_busy=0, ptr=owner, IDLE). The release check takes priority over i_req[owner].
  - Else if i_req[owner]=1: capture i_data[owner] into o_d, pulse o_en/o_ack, go to WRITE.
  - Else: stay in LOCKED.
- Throughput:
  - Unlocked: one write per 2 cycles, because WRITE always returns to IDLE.
  - Locked: one write per 2 cycles (WRITE↔LOCKED).
- Requests are level-sampled, not queued. A request dropped before being sampled in IDLE is lost without an ack.
- i_lock is only examined for the current owner. i_lock from a non-owner has no effect.
- o_hold_expired is tied 0 when the optional feature is compiled out.

Optional Feature:
- Macro: REG_ARB_HOLD_LIMIT_EN.
- Defined:
  - A tenure counter (width clog2(MAX_HOLD+1)) clears on grant and increments every cycle in WRITE or LOCKED.
  - When it equals MAX_HOLD, the next edge forces release to IDLE regardless of i_lock: o_gnt=0, ptr=owner, o_hold_expired pulses 1 cycle.
  - If this coincides with WRITE, the write completes first (o_en already issued) and the release replaces the LOCKED transition.
- Not defined: no counter, no forced release, o_hold_expired constant 0.

Test Plan:
- Reset: assert i_rst 2 cycles while i_req=4'b1111 → all outputs 0 during reset. First grant after release is o_gnt=4'b0001.
- Round robin: i_req=4'b1111 held, i_lock=0, N_REQ=4 → grants 0,1,2,3,0 on every 2nd cycle. Each o_en pulse carries that requester's data, e.g. 8'hA0..8'hA3.
- Lock burst: requester 2 holds i_lock=1 and i_req=1 with data 8'h11, 8'h22, 8'h33; requester 0 also requesting → three o_en pulses with o_d 11,22,33, o_owner=2. Requester 0 is granted 2 cycles after i_lock[2] drops.
- Reset mid-operation: i_rst asserted in the WRITE cycle → o_en=0 and o_gnt=0 after that edge, ptr=3.
- Dropped request: i_req[1] pulsed for one cycle while owner 3 is LOCKED → no ack to 1 and no write of its data.
- Hold limit (macro defined, MAX_HOLD=4): requester 1 locks with i_req=1 continuously → 3 writes (tenure cycles 0,2,4), forced release after tenure 4, o_hold_expired=1 for one cycle. Without the macro, grant is held indefinitely.
